// File: rtl/stim_gen.sv
// Burst stimulus generator driving a cmd/adr/data valid-ready channel.
// Define STIM_GEN_CHECKSUM_EN to add the csum output (XOR of accepted data).
module stim_gen #(
  parameter int          CMD_W  = 4,
  parameter int          ADR_W  = 8,
  parameter int          DATA_W = 8,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CMD_W-1:0]  cfg_cmd,
  input  logic [ADR_W-1:0]  cfg_adr_lo,
  input  logic [ADR_W-1:0]  cfg_adr_hi,
  input  logic [DATA_W-1:0] cfg_data_max,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              valid,
  input  logic              ready,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent
`ifdef STIM_GEN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [ADR_W:0]  ONE_A  = 1;
  localparam logic [DATA_W:0] ONE_D  = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic                mode_q;
  logic [ADR_W-1:0]    lo_q;
  logic [ADR_W-1:0]    hi_q;
  logic [DATA_W-1:0]   dmax_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [15:0]         lfsr_next;
  logic [CNT_W-1:0]    sent_inc;
  logic                accept;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign sent_inc  = sent + 1'b1;
  assign accept    = valid && ready;

  // Inverted ranges (hi < lo) collapse to a single address at lo.
  function automatic logic [ADR_W-1:0] rand_adr(input logic [15:0] l,
                                                input logic [ADR_W-1:0] lo,
                                                input logic [ADR_W-1:0] hi);
    logic [ADR_W:0] span;
    logic [16:0]    off;
    span = (hi < lo) ? ONE_A : ({1'b0, hi} - {1'b0, lo} + ONE_A);
    off  = {1'b0, l} % 17'(span);
    return lo + off[ADR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rand_data(input logic [15:0] l,
                                                  input logic [DATA_W-1:0] dmax);
    logic [16:0] dd;
    dd = {1'b0, l[7:0], l[15:8]} % 17'({1'b0, dmax} + ONE_D);
    return dd[DATA_W-1:0];
  endfunction

  function automatic logic [ADR_W-1:0] incr_adr(input logic [ADR_W-1:0] cur,
                                                input logic [ADR_W-1:0] lo,
                                                input logic [ADR_W-1:0] hi);
    return (hi < lo || cur == hi) ? lo : cur + ADR_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] incr_data(input logic [DATA_W-1:0] s,
                                                  input logic [DATA_W-1:0] dmax);
    logic [DATA_W:0] q;
    q = {1'b0, s} % ({1'b0, dmax} + ONE_D);
    return q[DATA_W-1:0];
  endfunction

  // The burst leaves RUN on the accept that reaches cnt_q, so sent never passes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= SEED_EFF;
      mode_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      dmax_q <= '0;
      cnt_q  <= '0;
      valid  <= 1'b0;
      cmd    <= '0;
      adr    <= '0;
      data   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sent   <= '0;
`ifdef STIM_GEN_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            lo_q   <= cfg_adr_lo;
            hi_q   <= cfg_adr_hi;
            dmax_q <= cfg_data_max;
            cnt_q  <= cfg_count;
            cmd    <= cfg_cmd;
            sent   <= '0;
            lfsr   <= lfsr_next;
            adr    <= mode ? cfg_adr_lo : rand_adr(lfsr_next, cfg_adr_lo, cfg_adr_hi);
            data   <= mode ? '0 : rand_data(lfsr_next, cfg_data_max);
`ifdef STIM_GEN_CHECKSUM_EN
            csum   <= '0;
`endif
            if (cfg_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              valid <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            sent <= sent_inc;
            lfsr <= lfsr_next;
            adr  <= mode_q ? incr_adr(adr, lo_q, hi_q) : rand_adr(lfsr_next, lo_q, hi_q);
            data <= mode_q ? incr_data(sent_inc[DATA_W-1:0], dmax_q)
                           : rand_data(lfsr_next, dmax_q);
`ifdef STIM_GEN_CHECKSUM_EN
            csum <= csum ^ data;
`endif
          end
          if ((accept && sent_inc == cnt_q) || abort) begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
